// File: rtl/spike_avl_arbiter.sv
// Two-master Avalon-MM arbiter: one outstanding transaction at a time, read timeout.
// Optional build macro SPIKE_ARB_M0_PRIORITY_EN: m0 wins every tie (otherwise round-robin).
module spike_avl_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 16,
    parameter int BE_W         = 4,
    parameter int RD_TIMEOUT   = 16,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA = 16'hDEAD
) (
    input  logic              avl_clk_i,
    input  logic              avl_reset_i,
    input  logic [ADDR_W-1:0] m0_address_i,
    input  logic [BE_W-1:0]   m0_byteenable_i,
    input  logic              m0_write_i,
    input  logic [DATA_W-1:0] m0_writedata_i,
    input  logic              m0_read_i,
    output logic              m0_waitrequest_o,
    output logic              m0_readdatavalid_o,
    output logic [DATA_W-1:0] m0_readdata_o,
    input  logic [ADDR_W-1:0] m1_address_i,
    input  logic [BE_W-1:0]   m1_byteenable_i,
    input  logic              m1_write_i,
    input  logic [DATA_W-1:0] m1_writedata_i,
    input  logic              m1_read_i,
    output logic              m1_waitrequest_o,
    output logic              m1_readdatavalid_o,
    output logic [DATA_W-1:0] m1_readdata_o,
    output logic [ADDR_W-1:0] s_address_o,
    output logic [BE_W-1:0]   s_byteenable_o,
    output logic              s_write_o,
    output logic [DATA_W-1:0] s_writedata_o,
    output logic              s_read_o,
    input  logic              s_waitrequest_i,
    input  logic              s_readdatavalid_i,
    input  logic [DATA_W-1:0] s_readdata_i,
    output logic              arb_timeout_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_RD_WAIT} state_t;

    localparam logic [7:0] TO_LAST = 8'(RD_TIMEOUT - 1);

    state_t      r_state;
    logic [1:0]  r_owner;       // one-hot, 0 = no owner
    logic        r_last_grant;  // 0 = m0, 1 = m1
    logic [7:0]  r_cnt;
    logic [1:0][DATA_W-1:0] r_rdata;

    logic        w_req0, w_req1, w_any, w_pick_m1, w_rd_done;
    logic [DATA_W-1:0] w_rdata;
    logic [1:0]  w_rdv, w_wait;

    assign w_req0 = m0_read_i | m0_write_i;
    assign w_req1 = m1_read_i | m1_write_i;
    assign w_any  = w_req0 | w_req1;

`ifdef SPIKE_ARB_M0_PRIORITY_EN
    assign w_pick_m1 = w_req1 & ~w_req0;
`else
    assign w_pick_m1 = w_req1 & (~w_req0 | ~r_last_grant);
`endif

    // Slave data wins over the timeout when both land on the same cycle.
    assign w_rd_done     = (r_state == ST_RD_WAIT) & (s_readdatavalid_i | (r_cnt == TO_LAST));
    assign w_rdata       = s_readdatavalid_i ? s_readdata_i : TIMEOUT_DATA;
    assign arb_timeout_o = w_rd_done & ~s_readdatavalid_i;

    always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
        if (!avl_reset_i) begin
            r_state        <= ST_IDLE;
            r_owner        <= 2'b00;
            r_last_grant   <= 1'b1;
            r_cnt          <= '0;
            s_address_o    <= '0;
            s_byteenable_o <= '0;
            s_writedata_o  <= '0;
            s_write_o      <= 1'b0;
            s_read_o       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_owner        <= w_pick_m1 ? 2'b10 : 2'b01;
                        r_last_grant   <= w_pick_m1;
                        s_address_o    <= w_pick_m1 ? m1_address_i : m0_address_i;
                        s_byteenable_o <= w_pick_m1 ? m1_byteenable_i : m0_byteenable_i;
                        s_writedata_o  <= w_pick_m1 ? m1_writedata_i : m0_writedata_i;
                        s_write_o      <= w_pick_m1 ? m1_write_i : m0_write_i;
                        s_read_o       <= w_pick_m1 ? (m1_read_i & ~m1_write_i)
                                                    : (m0_read_i & ~m0_write_i);
                        r_state        <= ST_CMD;
                    end else begin
                        r_owner <= 2'b00;
                    end
                end
                ST_CMD: begin
                    if (!s_waitrequest_i) begin
                        s_read_o  <= 1'b0;
                        s_write_o <= 1'b0;
                        if (s_read_o) begin
                            r_state <= ST_RD_WAIT;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_owner <= 2'b00;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (w_rd_done) begin
                        r_state <= ST_IDLE;
                        r_owner <= 2'b00;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            assign w_rdv[gi]  = w_rd_done & r_owner[gi];
            assign w_wait[gi] = ~((r_state == ST_CMD) & r_owner[gi] & ~s_waitrequest_i);

            always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
                if (!avl_reset_i)
                    r_rdata[gi] <= '0;
                else if (w_rdv[gi])
                    r_rdata[gi] <= w_rdata;
            end
        end
    endgenerate

    assign m0_waitrequest_o   = w_wait[0];
    assign m1_waitrequest_o   = w_wait[1];
    assign m0_readdatavalid_o = w_rdv[0];
    assign m1_readdatavalid_o = w_rdv[1];
    assign m0_readdata_o      = w_rdv[0] ? w_rdata : r_rdata[0];
    assign m1_readdata_o      = w_rdv[1] ? w_rdata : r_rdata[1];
endmodule

// File: tb/tb_spike_avl_arbiter.sv
// Directed self-checking bench for spike_avl_arbiter (define SPIKE_ARB_M0_PRIORITY_EN for fixed priority).
module tb_spike_avl_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] m0_addr, m1_addr, s_addr;
    logic [3:0]  m0_be, m1_be, s_be;
    logic        m0_wr, m1_wr, m0_rd, m1_rd, s_wr, s_rd;
    logic [15:0] m0_wdata, m1_wdata, s_wdata;
    logic        m0_wait, m1_wait, m0_rdv, m1_rdv;
    logic [15:0] m0_rdata, m1_rdata, s_rdata;
    logic        s_wait, s_rdv, tmo;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    spike_avl_arbiter dut (
        .avl_clk_i(clk), .avl_reset_i(rst_n),
        .m0_address_i(m0_addr), .m0_byteenable_i(m0_be), .m0_write_i(m0_wr),
        .m0_writedata_i(m0_wdata), .m0_read_i(m0_rd), .m0_waitrequest_o(m0_wait),
        .m0_readdatavalid_o(m0_rdv), .m0_readdata_o(m0_rdata),
        .m1_address_i(m1_addr), .m1_byteenable_i(m1_be), .m1_write_i(m1_wr),
        .m1_writedata_i(m1_wdata), .m1_read_i(m1_rd), .m1_waitrequest_o(m1_wait),
        .m1_readdatavalid_o(m1_rdv), .m1_readdata_o(m1_rdata),
        .s_address_o(s_addr), .s_byteenable_o(s_be), .s_write_o(s_wr),
        .s_writedata_o(s_wdata), .s_read_o(s_rd), .s_waitrequest_i(s_wait),
        .s_readdatavalid_i(s_rdv), .s_readdata_i(s_rdata), .arb_timeout_o(tmo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_be = 4'hF; m1_be = 4'hF;
        m0_wr = 0; m1_wr = 0; m0_rd = 0; m1_rd = 0;
        m0_wdata = '0; m1_wdata = '0;
        s_wait = 0; s_rdv = 0; s_rdata = '0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if ({s_rd, s_wr, s_addr, s_wdata, s_be} !== 36'd0) begin n_err++;
            $display("FAIL reset_s_bus: got %h exp 0", {s_rd, s_wr, s_addr, s_wdata, s_be}); end
        n_cmp++; if ({m0_wait, m1_wait, m0_rdv, m1_rdv, tmo} !== 5'b11000) begin n_err++;
            $display("FAIL reset_ctrl: got %b exp 11000", {m0_wait, m1_wait, m0_rdv, m1_rdv, tmo}); end
        n_cmp++; if ({m0_rdata, m1_rdata} !== 32'd0) begin n_err++;
            $display("FAIL reset_rdata: got %h exp 0", {m0_rdata, m1_rdata}); end
        $display("txn reset: done");
    endtask

    task automatic test_single_write();
        do_reset();
        m0_addr = 14'd1; m0_wdata = 16'd1; m0_be = 4'h3; m0_wr = 1;
        tick();
        n_cmp++; if ({s_wr, s_rd, s_addr, s_wdata, s_be} !== {1'b1, 1'b0, 14'd1, 16'd1, 4'h3}) begin n_err++;
            $display("FAIL wr_cmd: got %b/%b addr %h data %h be %h exp 1/0 addr 1 data 1 be 3", s_wr, s_rd, s_addr, s_wdata, s_be); end
        n_cmp++; if ({m0_wait, m1_wait} !== 2'b01) begin n_err++;
            $display("FAIL wr_wait_accept: got %b exp 01", {m0_wait, m1_wait}); end
        m0_wr = 0;
        tick();
        n_cmp++; if ({s_wr, m0_wait} !== 2'b01) begin n_err++;
            $display("FAIL wr_done: got s_wr/m0_wait %b exp 01", {s_wr, m0_wait}); end
        tick();
        n_cmp++; if ({s_wr, s_rd, m0_wait} !== 3'b001) begin n_err++;
            $display("FAIL wr_idle: got %b exp 001", {s_wr, s_rd, m0_wait}); end
        $display("txn single_write: m0 addr 1 data 1");
    endtask

    task automatic test_dual_read();
        do_reset();
        m0_addr = 14'd2; m1_addr = 14'd3; m0_rd = 1; m1_rd = 1;
        tick();
        n_cmp++; if ({s_rd, s_addr, m0_wait, m1_wait} !== {1'b1, 14'd2, 2'b01}) begin n_err++;
            $display("FAIL rd_first_grant: got rd %b addr %h wait %b%b exp rd 1 addr 2 wait 01", s_rd, s_addr, m0_wait, m1_wait); end
        m0_rd = 0;
        tick();
        s_rdv = 1; s_rdata = 16'h0011;
        #1;
        n_cmp++; if ({m0_rdv, m1_rdv, m0_rdata} !== {2'b10, 16'h0011}) begin n_err++;
            $display("FAIL rd_m0_data: got rdv %b%b data %h exp 10 0011", m0_rdv, m1_rdv, m0_rdata); end
        tick();
        s_rdv = 0; s_rdata = 16'h7777;
        #1;
        n_cmp++; if ({m0_rdv, m1_rdv, m0_rdata} !== {2'b00, 16'h0011}) begin n_err++;
            $display("FAIL rd_m0_hold: got rdv %b%b data %h exp 00 0011", m0_rdv, m1_rdv, m0_rdata); end
        tick();
        n_cmp++; if ({s_rd, s_addr, m0_wait, m1_wait} !== {1'b1, 14'd3, 2'b10}) begin n_err++;
            $display("FAIL rd_second_grant: got rd %b addr %h wait %b%b exp rd 1 addr 3 wait 10", s_rd, s_addr, m0_wait, m1_wait); end
        m1_rd = 0;
        tick();
        s_rdv = 1; s_rdata = 16'h0022;
        #1;
        n_cmp++; if ({m0_rdv, m1_rdv, m1_rdata, m0_rdata} !== {2'b01, 16'h0022, 16'h0011}) begin n_err++;
            $display("FAIL rd_m1_data: got rdv %b%b m1 %h m0 %h exp 01 0022 0011", m0_rdv, m1_rdv, m1_rdata, m0_rdata); end
        tick();
        s_rdv = 0;
        #1;
        n_cmp++; if ({m0_rdv, m1_rdv} !== 2'b00) begin n_err++;
            $display("FAIL rd_m1_single: got rdv %b%b exp 00", m0_rdv, m1_rdv); end
        $display("txn dual_read: m0=0011 m1=0022");
    endtask

    task automatic test_wait_stall();
        do_reset();
        s_wait = 1;
        m1_addr = 14'd5; m1_wdata = 16'hBEEF; m1_be = 4'hA; m1_wr = 1;
        tick();
        m0_addr = 14'd7; m0_wdata = 16'h1234; m0_wr = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if ({s_wr, s_addr, s_wdata, s_be, m0_wait, m1_wait} !== {1'b1, 14'd5, 16'hBEEF, 4'hA, 2'b11}) begin n_err++;
                $display("FAIL stall_hold[%0d]: got wr %b addr %h data %h be %h wait %b%b", i, s_wr, s_addr, s_wdata, s_be, m0_wait, m1_wait); end
            if (i < 4) tick();
        end
        s_wait = 0;
        #1;
        n_cmp++; if ({m0_wait, m1_wait} !== 2'b10) begin n_err++;
            $display("FAIL stall_release: got wait %b%b exp 10", m0_wait, m1_wait); end
        m1_wr = 0;
        tick();
        n_cmp++; if ({s_wr, m0_wait} !== 2'b01) begin n_err++;
            $display("FAIL stall_m0_not_yet: got s_wr %b m0_wait %b exp 0 1", s_wr, m0_wait); end
        tick();
        n_cmp++; if ({s_wr, s_addr, s_wdata, m0_wait} !== {1'b1, 14'd7, 16'h1234, 1'b0}) begin n_err++;
            $display("FAIL stall_m0_grant: got wr %b addr %h data %h wait %b exp 1 7 1234 0", s_wr, s_addr, s_wdata, m0_wait); end
        m0_wr = 0;
        tick();
        $display("txn wait_stall: m1 write held 5 cycles then m0");
    endtask

    task automatic test_timeout();
        do_reset();
        m0_addr = 14'd9; m0_rd = 1;
        tick();
        m0_rd = 0;
        tick();
        for (int i = 0; i < 15; i++) begin
            n_cmp++; if ({m0_rdv, m1_rdv, tmo} !== 3'b000) begin n_err++;
                $display("FAIL tmo_early[%0d]: got rdv %b%b tmo %b exp 000", i, m0_rdv, m1_rdv, tmo); end
            tick();
        end
        n_cmp++; if ({m0_rdv, m1_rdv, tmo, m0_rdata} !== {3'b101, 16'hDEAD}) begin n_err++;
            $display("FAIL tmo_fire: got rdv %b%b tmo %b data %h exp 101 DEAD", m0_rdv, m1_rdv, tmo, m0_rdata); end
        tick();
        n_cmp++; if ({m0_rdv, tmo, m0_rdata} !== {2'b00, 16'hDEAD}) begin n_err++;
            $display("FAIL tmo_once: got rdv %b tmo %b data %h exp 00 DEAD", m0_rdv, tmo, m0_rdata); end
        m1_addr = 14'h33; m1_wr = 1;
        tick();
        n_cmp++; if ({s_wr, s_addr, m1_wait} !== {1'b1, 14'h33, 1'b0}) begin n_err++;
            $display("FAIL tmo_next_grant: got wr %b addr %h wait %b exp 1 33 0", s_wr, s_addr, m1_wait); end
        m1_wr = 0;
        tick();
        $display("txn timeout: m0 read -> DEAD");
    endtask

    task automatic test_reset_rd_wait();
        do_reset();
        m1_addr = 14'd4; m1_rd = 1;
        tick();
        m1_rd = 0;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({s_rd, s_wr, s_addr, m0_wait, m1_wait, m0_rdv, m1_rdv, tmo} !== {2'b00, 14'd0, 5'b11000}) begin n_err++;
            $display("FAIL async_reset: got rd %b wr %b addr %h wait %b%b rdv %b%b tmo %b", s_rd, s_wr, s_addr, m0_wait, m1_wait, m0_rdv, m1_rdv, tmo); end
        tick();
        rst_n = 1'b1;
        s_rdv = 1; s_rdata = 16'h5555;
        #1;
        n_cmp++; if ({m0_rdv, m1_rdv, m0_rdata, m1_rdata} !== 34'd0) begin n_err++;
            $display("FAIL late_rdv: got rdv %b%b data %h %h exp 00 0 0", m0_rdv, m1_rdv, m0_rdata, m1_rdata); end
        tick();
        s_rdv = 0;
        $display("txn reset_rd_wait: pending m1 read abandoned");
    endtask

    task automatic test_back_to_back();
        logic m0_expected;
        do_reset();
        m0_addr = 14'h10; m1_addr = 14'h20; m0_wr = 1; m1_wr = 1;
        for (int k = 0; k < 4; k++) begin
`ifdef SPIKE_ARB_M0_PRIORITY_EN
            m0_expected = 1'b1;
`else
            m0_expected = (k % 2) == 0;
`endif
            tick();
            n_cmp++; if ({m0_wait, m1_wait, s_addr} !== {~m0_expected, m0_expected, m0_expected ? 14'h10 : 14'h20}) begin n_err++;
                $display("FAIL b2b_grant[%0d]: got wait %b%b addr %h exp m0_wins=%b", k, m0_wait, m1_wait, s_addr, m0_expected); end
            tick();
            n_cmp++; if (s_wr !== 1'b0) begin n_err++;
                $display("FAIL b2b_idle[%0d]: got s_wr %b exp 0", k, s_wr); end
            $display("txn back_to_back[%0d]: owner m%0d addr %h", k, m0_expected ? 0 : 1, s_addr);
        end
        m0_wr = 0; m1_wr = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_dual_read();
        test_wait_stall();
        test_timeout();
        test_reset_rd_wait();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
